// File: rtl/uart_tx_ctrl.sv
// RS-232 transmit sequencer: latches a byte, computes its parity and steps the
// bit-multiplexer selector through start, data, parity and stop bits.
module uart_tx_ctrl #(
    parameter int BAUD_DIV = 5208,
    parameter bit PAR_EN   = 1'b1,
    parameter bit PAR_ODD  = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [7:0] d_i,
    output logic [7:0] d_o,
    output logic       p_o,
    output logic [3:0] sel_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        r_state, w_state_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [2:0]    r_idx, w_idx_n;
    logic [7:0]    r_d, w_d_n;
    logic          r_p, w_p_n;
    logic [3:0]    r_sel, w_sel_n;
    logic          r_busy, w_busy_n;
    logic          r_done, w_done_n;
    logic          w_bit_end;

    assign w_bit_end = (r_cnt == CNT_MAX);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_d     <= '0;
            r_p     <= 1'b0;
            r_sel   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            r_d     <= w_d_n;
            r_p     <= w_p_n;
            r_sel   <= w_sel_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
        end
    end

    // Outputs are computed one step ahead so every output is a flop.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = w_bit_end ? '0 : r_cnt + 1'b1;
        w_idx_n   = r_idx;
        w_d_n     = r_d;
        w_p_n     = r_p;
        w_sel_n   = r_sel;
        w_busy_n  = r_busy;
        w_done_n  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_n = '0;
                if (start_i) begin
                    w_d_n     = d_i;
                    w_p_n     = ^d_i ^ PAR_ODD;
                    w_state_n = S_START;
                    w_sel_n   = 4'd1;
                    w_busy_n  = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_n = S_DATA;
                    w_idx_n   = '0;
                    w_sel_n   = 4'd2;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_idx == 3'd7) begin
                        if (PAR_EN) begin
                            w_state_n = S_PARITY;
                            w_sel_n   = 4'd10;
                        end else begin
                            w_state_n = S_STOP;
                            w_sel_n   = 4'd0;
                        end
                    end else begin
                        w_idx_n = r_idx + 3'd1;
                        w_sel_n = 4'(r_idx) + 4'd3;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_n = S_STOP;
                    w_sel_n   = 4'd0;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_n = S_IDLE;
                    w_busy_n  = 1'b0;
                    w_done_n  = 1'b1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_sel_n   = 4'd0;
                w_busy_n  = 1'b0;
            end
        endcase
    end

    assign d_o    = r_d;
    assign p_o    = r_p;
    assign sel_o  = r_sel;
    assign busy_o = r_busy;
    assign done_o = r_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: four parameter sets checked frame by frame
// with immediate assertions.
module tb_uart_tx_ctrl;

    logic       clk;
    logic       rst_n;
    logic       st[4];
    logic [7:0] din[4];
    logic [7:0] dq[4];
    logic       pq[4];
    logic [3:0] sel[4];
    logic       busy[4];
    logic       done[4];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_ctrl #(.BAUD_DIV(4), .PAR_EN(1'b1), .PAR_ODD(1'b0)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(st[0]), .d_i(din[0]),
        .d_o(dq[0]), .p_o(pq[0]), .sel_o(sel[0]), .busy_o(busy[0]),
        .done_o(done[0]));
    uart_tx_ctrl #(.BAUD_DIV(4), .PAR_EN(1'b1), .PAR_ODD(1'b1)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(st[1]), .d_i(din[1]),
        .d_o(dq[1]), .p_o(pq[1]), .sel_o(sel[1]), .busy_o(busy[1]),
        .done_o(done[1]));
    uart_tx_ctrl #(.BAUD_DIV(4), .PAR_EN(1'b0), .PAR_ODD(1'b0)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(st[2]), .d_i(din[2]),
        .d_o(dq[2]), .p_o(pq[2]), .sel_o(sel[2]), .busy_o(busy[2]),
        .done_o(done[2]));
    uart_tx_ctrl #(.BAUD_DIV(2), .PAR_EN(1'b1), .PAR_ODD(1'b0)) u3 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(st[3]), .d_i(din[3]),
        .d_o(dq[3]), .p_o(pq[3]), .sel_o(sel[3]), .busy_o(busy[3]),
        .done_o(done[3]));

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Downstream bit multiplexer: what the serial line carries.
    function automatic logic line(input logic [3:0] s, input logic [7:0] d,
                                  input logic p);
        if (s == 4'd0) return 1'b1;
        if (s == 4'd1) return 1'b0;
        if (s == 4'd10) return p;
        if (s <= 4'd9) return d[s-4'd2];
        return 1'b1;
    endfunction

    task automatic accept(input int u, input logic [7:0] data);
        st[u]  = 1'b1;
        din[u] = data;
        step();
        st[u]  = 1'b0;
    endtask

    // Called at T+1; returns in the done_o cycle without stepping past it.
    task automatic frame_chk(input int u, input int b, input bit pe,
                             input logic [7:0] dexp, input logic pexp,
                             input int inj);
        int nb;
        logic [3:0] es;
        logic el;
        nb = pe ? 11 : 10;
        for (int k = 0; k < nb; k++) begin
            if (k == 0) begin
                es = 4'd1; el = 1'b0;
            end else if (k <= 8) begin
                es = 4'(k + 1); el = dexp[k-1];
            end else if (pe && k == 9) begin
                es = 4'd10; el = pexp;
            end else begin
                es = 4'd0; el = 1'b1;
            end
            for (int c = 0; c < b; c++) begin
                chk($sformatf("u%0d sel k%0d c%0d", u, k, c), 32'(sel[u]), 32'(es));
                chk($sformatf("u%0d busy k%0d c%0d", u, k, c), 32'(busy[u]), 1);
                chk($sformatf("u%0d d_o k%0d", u, k), 32'(dq[u]), 32'(dexp));
                chk($sformatf("u%0d p_o k%0d", u, k), 32'(pq[u]), 32'(pexp));
                if (c == 0)
                    chk($sformatf("u%0d line k%0d", u, k),
                        32'(line(sel[u], dq[u], pq[u])), 32'(el));
                st[u] = (k * b + c == inj);
                if (k * b + c == inj) din[u] = 8'hFF;
                step();
            end
        end
        st[u] = 1'b0;
        chk($sformatf("u%0d done end", u), 32'(done[u]), 1);
        chk($sformatf("u%0d busy end", u), 32'(busy[u]), 0);
        chk($sformatf("u%0d sel end", u), 32'(sel[u]), 0);
        chk($sformatf("u%0d d_o end", u), 32'(dq[u]), 32'(dexp));
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            st[i]  = 1'b0;
            din[i] = 8'h00;
        end
        repeat (2) step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst sel u%0d", i), 32'(sel[i]), 0);
            chk($sformatf("rst busy u%0d", i), 32'(busy[i]), 0);
            chk($sformatf("rst done u%0d", i), 32'(done[i]), 0);
            chk($sformatf("rst d_o u%0d", i), 32'(dq[i]), 0);
            chk($sformatf("rst p_o u%0d", i), 32'(pq[i]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Even parity A5 with an ignored mid-frame start carrying FF.
        accept(0, 8'hA5);
        frame_chk(0, 4, 1'b1, 8'hA5, 1'b0, 22);
        step();
        chk("u0 done pulse width", 32'(done[0]), 0);
        for (int i = 0; i < 8; i++) begin
            chk("u0 no queued frame busy", 32'(busy[0]), 0);
            chk("u0 no queued frame sel", 32'(sel[0]), 0);
            step();
        end

        // 07 even parity, then back-to-back 3C started in the done cycle.
        accept(0, 8'h07);
        frame_chk(0, 4, 1'b1, 8'h07, 1'b1, -1);
        st[0]  = 1'b1;
        din[0] = 8'h3C;
        step();
        st[0]  = 1'b0;
        chk("b2b sel", 32'(sel[0]), 1);
        chk("b2b done", 32'(done[0]), 0);
        frame_chk(0, 4, 1'b1, 8'h3C, 1'b0, -1);
        step();

        accept(1, 8'h07);
        frame_chk(1, 4, 1'b1, 8'h07, 1'b0, -1);
        step();

        accept(2, 8'h07);
        frame_chk(2, 4, 1'b0, 8'h07, 1'b1, -1);
        step();

        accept(3, 8'h00);
        frame_chk(3, 2, 1'b1, 8'h00, 1'b0, -1);
        step();

        // Reset during D3, release with start already high.
        accept(0, 8'hA5);
        n = 0;
        while (sel[0] != 4'd5 && n < 100) begin
            step();
            n++;
        end
        chk("reach D3 within bound", 32'(n < 100), 1);
        rst_n = 1'b0;
        #1;
        chk("async rst sel", 32'(sel[0]), 0);
        chk("async rst busy", 32'(busy[0]), 0);
        chk("async rst d_o", 32'(dq[0]), 0);
        chk("async rst p_o", 32'(pq[0]), 0);
        st[0]  = 1'b1;
        din[0] = 8'hC3;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        st[0] = 1'b0;
        frame_chk(0, 4, 1'b1, 8'hC3, 1'b0, -1);
        step();
        chk("final done low", 32'(done[0]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Sequencing controller for the RS-232 transmitter: accepts a byte on a single-cycle start strobe, latches it, computes its parity bit and steps a 4-bit selector through stop/idle → start → D0..D7 → parity → stop, holding each step for one baud period. It sits directly upstream of the transmit bit multiplexer and drives that block's data, parity and selector inputs. The multiplexer's output is the serial line.

## Interface
- BAUD_DIV, 5208: clock cycles per bit (50 MHz / 9600 baud); legal range ≥ 2.
- PAR_EN, 1: 1 = parity bit sent; 0 = parity step skipped.
- PAR_ODD, 0: 0 = even parity; 1 = odd parity.

- clk_i  input  1  system clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- start_i  input  1  transmit request, sampled only in IDLE.
- d_i  input  8  byte to send, sampled in the cycle start_i is accepted.
- d_o  output  8  latched byte to multiplexer data input.
- p_o  output  1  parity of latched byte to multiplexer parity input.
- sel_o  output  4  bit selector to multiplexer. Encoding: 0 = stop/idle (line high), 1 = start, 2..9 = D0..D7, 10 = parity.
- busy_o  output  1  high from the cycle after acceptance until the frame ends.
- done_o  output  1  one-cycle pulse at frame end.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - sel_o = 0 and busy_o = 0.
  - When start_i = 1, latch d_i into d_o and compute p_o = ^d_i ^ PAR_ODD (registered with d_o).
  - Clear the baud counter and go to START.
- START: sel_o = 1.
- DATA: sel_o = 2 + bit_idx, with bit_idx running 0..7 (LSB first).
- PARITY: sel_o = 10. Entered from DATA only when PAR_EN = 1; otherwise DATA goes straight to STOP.
- STOP: sel_o = 0. After one baud period, go to IDLE and pulse done_o.
- Baud counter:
  - Width $clog2(BAUD_DIV); counts 0..BAUD_DIV-1.
  - At BAUD_DIV-1 the bit ends: the counter wraps to 0 and the state or bit_idx advances.
- bit_idx:
  - 3 bits; increments at each DATA bit end.
  - Leaving DATA happens at the bit end where bit_idx = 7.
- start_i while busy_o = 1 is ignored; no queuing.
- d_i changes after acceptance do not affect d_o or p_o until the next acceptance.
- d_o and p_o hold their value after the frame until the next acceptance.
- Registered outputs only; no combinational path from inputs to outputs.

## Timing
- Reset values, applied immediately on rst_ni low, including mid-frame:
  - state IDLE; sel_o = 0, so the line goes high at once.
  - d_o = 0, p_o = 0, busy_o = 0, done_o = 0, counters 0.
- Acceptance edge T (start_i = 1 in IDLE): at T+1, sel_o = 1 and busy_o = 1.
- Each sel_o value is held exactly BAUD_DIV cycles.
- Frame length (cycles with busy_o = 1): (11 × BAUD_DIV) with PAR_EN = 1, (10 × BAUD_DIV) with PAR_EN = 0.
- At the end of the STOP bit, with F = 11 or 10 (the number of bits in the frame):
  - at cycle T + 1 + F × BAUD_DIV, busy_o = 0 and done_o = 1 for that single cycle.
  - sel_o stays 0.
- Back-to-back frames: start_i asserted in the done_o cycle is accepted, so the next START begins the following cycle. Minimum idle gap is 1 cycle.
- start_i held high continuously: a new frame starts each time IDLE is reached.
- rst_ni deasserted with start_i high: accepted on the first rising edge after deassertion.

## Test plan
- Even parity byte, BAUD_DIV = 4, PAR_EN = 1, PAR_ODD = 0:
  - Stimulus: start_i pulse, d_i = 0xA5.
  - Response: d_o = 0xA5, p_o = 0.
  - sel_o sequence 1,2,3,4,5,6,7,8,9,10,0, each held 4 cycles.
  - Serial line through the multiplexer reads 0,1,0,1,0,0,1,0,1,0,1.
  - busy_o high for 44 cycles, then a one-cycle done_o.
- Odd parity and parity disabled:
  - d_i = 0x07 with PAR_ODD = 1: p_o = 0. With PAR_ODD = 0: p_o = 1.
  - PAR_EN = 0, BAUD_DIV = 4: sel_o never equals 10; busy_o high for 40 cycles.
- Ignored start and input stability:
  - Pulse start_i = 1 mid-frame with d_i = 0xFF.
  - Current frame is unchanged and no second frame follows.
  - d_o keeps its original value for the whole frame.
- Back-to-back frames:
  - Assert start_i in the done_o cycle with d_i = 0x3C.
  - sel_o = 1 on the next cycle; d_o = 0x3C, p_o = 0 (even parity).
- Reset mid-frame:
  - Drop rst_ni during the D3 bit (sel_o = 5).
  - Same cycle: sel_o = 0, busy_o = 0, d_o = 0.
  - After release, start_i is accepted and a full, correct frame follows.
- Minimum divider: BAUD_DIV = 2, d_i = 0x00, PAR_EN = 1, PAR_ODD = 0.
  - Each sel_o value lasts 2 cycles; the frame lasts 22 cycles; p_o = 0.
